// File: rtl/regbank_pkg.sv
// Shared types and sizing for the register-bank write-back block.
// Imported by the arbiter and the write-back top.
package regbank_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int N_REGS     = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    RR_A = 1'b0,
    RR_M = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-input write-back arbiter: round-robin between A (bit 0)
// and M (bit 1), or A-always-wins when PRIO_FIXED is set.
module wb_rr_arbiter
  import regbank_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic [1:0] i_Req,
  output logic [1:0] o_Grant
);

  rr_ptr_e rr_q, rr_d;

  always_ff @(posedge i_CLK) begin
    if (i_RST) rr_q <= RR_A;
    else       rr_q <= rr_d;
  end

  always_comb begin
    o_Grant = 2'b00;
    rr_d    = rr_q;
    if (!i_RST) begin
      unique case (i_Req)
        2'b01:   o_Grant = 2'b01;
        2'b10:   o_Grant = 2'b10;
        2'b11: begin
          if (PRIO_FIXED || rr_q == RR_A) o_Grant = 2'b01;
          else                            o_Grant = 2'b10;
        end
        default: o_Grant = 2'b00;
      endcase
    end
    // pointer always moves to the requester that just lost out
    if (o_Grant[0]) rr_d = RR_M;
    if (o_Grant[1]) rr_d = RR_A;
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Register-bank write port owner: A/M arbitration, two-phase
// write sequencing, pending scoreboard and decode stall.
module regbank_wb_arbiter
  import regbank_pkg::wb_req_t;
#(
  parameter int ADDR_W     = regbank_pkg::REG_ADDR_W,
  parameter int DATA_W     = regbank_pkg::REG_DATA_W,
  parameter int N_REGS     = regbank_pkg::N_REGS,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_A_Valid,
  input  logic [ADDR_W-1:0] i_A_Addr,
  input  logic [DATA_W-1:0] i_A_Data,
  output logic              o_A_Ready,
  input  logic              i_M_Valid,
  input  logic [ADDR_W-1:0] i_M_Addr,
  input  logic [DATA_W-1:0] i_M_Data,
  output logic              o_M_Ready,
  input  logic              i_Issue,
  input  logic              i_IssueWrites,
  input  logic [ADDR_W-1:0] i_IssueDest,
  input  logic [ADDR_W-1:0] i_AddrReg1,
  input  logic [ADDR_W-1:0] i_AddrReg2,
  output logic              o_Stall,
  output logic              o_WriteBack,
  output logic [ADDR_W-1:0] o_AddrRegDest,
  output logic [DATA_W-1:0] o_WriteData,
  output logic [N_REGS-1:0] o_Pending
);

  wb_req_t     req_a, req_m;
  logic [1:0]  grant;
  logic        any_grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic              wb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dat1_q;
  logic [DATA_W-1:0] wdat_q;
  logic              cmt_q;
  logic [ADDR_W-1:0] cmt_addr_q;
  logic [N_REGS-1:0] pend_q, pend_d;

  logic hazard;
  logic issue_set;

  assign req_a = '{valid: i_A_Valid, addr: i_A_Addr, data: i_A_Data};
  assign req_m = '{valid: i_M_Valid, addr: i_M_Addr, data: i_M_Data};

  wb_rr_arbiter #(
    .PRIO_FIXED (PRIO_FIXED)
  ) u_arb (
    .i_CLK   (i_CLK),
    .i_RST   (i_RST),
    .i_Req   ({req_m.valid, req_a.valid}),
    .o_Grant (grant)
  );

  assign o_A_Ready = grant[0];
  assign o_M_Ready = grant[1];
  assign any_grant = |grant;
  assign win_addr  = grant[1] ? req_m.addr : req_a.addr;
  assign win_data  = grant[1] ? req_m.data : req_a.data;

  // address phase -> data phase -> commit, one stage each
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wb_q       <= 1'b0;
      addr_q     <= '0;
      dat1_q     <= '0;
      wdat_q     <= '0;
      cmt_q      <= 1'b0;
      cmt_addr_q <= '0;
      pend_q     <= '0;
    end else begin
      wb_q       <= any_grant;
      if (any_grant) begin
        addr_q <= win_addr;
        dat1_q <= win_data;
      end
      if (wb_q) wdat_q <= dat1_q;
      cmt_q      <= wb_q;
      cmt_addr_q <= addr_q;
      pend_q     <= pend_d;
    end
  end

  assign hazard = pend_q[i_AddrReg1]
                | pend_q[i_AddrReg2]
                | (i_IssueWrites & pend_q[i_IssueDest]);

  assign o_Stall   = ~i_RST & i_Issue & hazard;
  assign issue_set = i_Issue & i_IssueWrites & ~o_Stall;

  // set is applied after clear so a same-edge set wins
  always_comb begin
    pend_d = pend_q;
    if (cmt_q)     pend_d[cmt_addr_q]  = 1'b0;
    if (issue_set) pend_d[i_IssueDest] = 1'b1;
  end

  assign o_WriteBack   = wb_q;
  assign o_AddrRegDest = addr_q;
  assign o_WriteData   = wdat_q;
  assign o_Pending     = pend_q;

endmodule
